// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared states, constants and helpers for the PLL lock sequencer
package pll_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_ARESET    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_t;

  // Saturation value of the 8-bit event counters
  localparam logic [7:0] CNT8_SAT = 8'hFF;

  // Default parameter values
  localparam int DEF_ARESET_CYC   = 16;
  localparam int DEF_LOCK_TIMEOUT = 100000;
  localparam int DEF_STABLE_CYC   = 1024;
  localparam int DEF_MAX_RETRY    = 3;
  localparam int DEF_SYNC_STAGES  = 2;

  // Saturating 8-bit increment
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == CNT8_SAT) ? v : v + 8'd1;
  endfunction

  // Largest of three integers, used to size the shared cycle counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-stage single-bit synchroniser with async active-high reset
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_seq.sv
// rtl/pll_lock_seq.sv - PLL reset/lock sequencer; PLL_LOSS_CNT_EN enables the lock-loss counter
module pll_lock_seq
  import pll_seq_pkg::*;
#(
  parameter int ARESET_CYC   = DEF_ARESET_CYC,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYC   = DEF_STABLE_CYC,
  parameter int MAX_RETRY    = DEF_MAX_RETRY,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_areset,
  output logic       sys_ready,
  output logic       seq_fail,
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  // The counter only ever counts up to (limit - 1) in one state, so clog2 of the
  // largest limit is wide enough and it never wraps.
  localparam int CNT_MAX = max3(ARESET_CYC, LOCK_TIMEOUT, STABLE_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t ARESET_LAST  = cnt_t'(ARESET_CYC - 1);
  localparam cnt_t TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t STABLE_LAST  = cnt_t'(STABLE_CYC - 1);

  pll_state_t state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [7:0] retry_q, retry_d;
  logic       areset_q, ready_q, fail_q;
  logic       locked_s;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Next-state, retry and shared-counter decisions
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_ARESET: begin
        if (cnt_q == ARESET_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock is tested first so a lock arriving on the timeout cycle wins
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = sat_inc8(retry_q);
          state_d = (int'(retry_d) >= MAX_RETRY) ? ST_FAIL : ST_ARESET;
        end
      end
      ST_STABLE: begin
        // A lock glitch restarts the wait but is not a failed attempt
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        if (!locked_s) state_d = ST_ARESET;
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_ARESET;
      end
    endcase

    // restart overrides anything decided above
    if (restart) begin
      state_d = ST_ARESET;
      retry_d = '0;
    end

    // RUN and FAIL have no timed exit, so the counter is parked there
    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == ST_RUN) || (state_q == ST_FAIL)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + cnt_t'(1);
    end
  end

  // State, shared counter and retry count registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_ARESET;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // Output flops decoded from the next state so they line up with state_q
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      areset_q <= 1'b1;
      ready_q  <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      areset_q <= (state_d == ST_ARESET) || (state_d == ST_FAIL);
      ready_q  <= (state_d == ST_RUN);
      fail_q   <= (state_d == ST_FAIL);
    end
  end

  assign pll_areset = areset_q;
  assign sys_ready  = ready_q;
  assign seq_fail   = fail_q;
  assign retry_cnt  = retry_q;

`ifdef PLL_LOSS_CNT_EN
  logic [7:0] loss_q;
  logic       loss_evt;

  // A lock drop in RUN counts as a loss unless restart pre-empts it
  assign loss_evt = (state_q == ST_RUN) && !locked_s && !restart;

  // Saturating lock-loss counter, cleared only by sys_rst
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)       loss_q <= '0;
    else if (loss_evt) loss_q <= sat_inc8(loss_q);
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// tb/tb_pll_lock_seq.sv - scoreboard bench for pll_lock_seq
module tb_pll_lock_seq;

  localparam int ARESET_CYC   = 16;
  localparam int LOCK_TIMEOUT = 300;
  localparam int STABLE_CYC   = 64;
  localparam int MAX_RETRY    = 3;
  localparam int SYNC_STAGES  = 2;
  localparam int BUDGET       = 2000;

`ifdef PLL_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       pll_locked;
  logic       restart;
  logic       pll_areset;
  logic       sys_ready;
  logic       seq_fail;
  logic [7:0] retry_cnt;
  logic [7:0] loss_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_loss = 0;
  int n;

  string sb_tag[$];
  int    sb_exp[$];

  always #5 clk = ~clk;

  pll_lock_seq #(
    .ARESET_CYC   (ARESET_CYC),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYC   (STABLE_CYC),
    .MAX_RETRY    (MAX_RETRY),
    .SYNC_STAGES  (SYNC_STAGES)
  ) dut (
    .sys_clk    (clk),
    .sys_rst    (sys_rst),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_areset (pll_areset),
    .sys_ready  (sys_ready),
    .seq_fail   (seq_fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int exp);
    sb_tag.push_back(tag);
    sb_exp.push_back(exp);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (sb_exp.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      chk(sb_tag.pop_front(), obs, sb_exp.pop_front());
    end
  endtask

  function automatic int loss_model();
    if (!LOSS_EN) return 0;
    return (exp_loss > 255) ? 255 : exp_loss;
  endfunction

  function automatic logic [7:0] probe(input int sel);
    case (sel)
      0:       return {7'd0, pll_areset};
      1:       return {7'd0, sys_ready};
      2:       return {7'd0, seq_fail};
      default: return retry_cnt;
    endcase
  endfunction

  // Steps negedges until the selected output equals val; n = -1 on budget expiry
  task automatic wait_for(input int sel, input logic [7:0] val, input int budget, output int cnt);
    cnt = 0;
    forever begin
      @(negedge clk);
      cnt++;
      if (probe(sel) === val) break;
      if (cnt >= budget) begin
        cnt = -1;
        break;
      end
    end
  endtask

  // Called on the negedge where pll_areset was just seen low
  task automatic lock_and_run(input int dly, input string tag);
    int w;
    repeat (dly) @(negedge clk);
    pll_locked = 1'b1;
    sb_push(tag, dly + SYNC_STAGES + STABLE_CYC + 1);
    wait_for(1, 8'd1, BUDGET, w);
    sb_pop((w < 0) ? -1 : dly + w);
    chk({tag, "_retry"}, retry_cnt, 0);
  endtask

  // Called while in RUN: drop lock, expect ready to fall and loss to count
  task automatic drop_lock();
    int w;
    pll_locked = 1'b0;
    exp_loss++;
    sb_push("drop_latency", SYNC_STAGES + 1);
    sb_push("loss_cnt", loss_model());
    wait_for(1, 8'd0, BUDGET, w);
    sb_pop(w);
    sb_pop(loss_cnt);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst    = 1'b0;
    pll_locked = 1'b0;
    restart    = 1'b0;
    #1 sys_rst = 1'b1;
    #2;
    chk("rst_areset", pll_areset, 1);
    chk("rst_ready",  sys_ready,  0);
    chk("rst_fail",   seq_fail,   0);
    chk("rst_retry",  retry_cnt,  0);
    chk("rst_loss",   loss_cnt,   0);
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;

    // Nominal lock 200 cycles after areset release
    wait_for(0, 8'd0, BUDGET, n);
    chk("nominal_areset_cycles", n, ARESET_CYC);
    lock_and_run(200, "nominal_ready_latency");

    // Loss in RUN, then re-lock
    drop_lock();
    chk("loss_areset_high", pll_areset, 1);
    wait_for(0, 8'd0, BUDGET, n);
    chk("loss_areset_cycles", n, ARESET_CYC);
    lock_and_run(0, "relock_ready_latency");

    // One-cycle lock glitch 20 cycles into STABLE
    drop_lock();
    wait_for(0, 8'd0, BUDGET, n);
    chk("glitch_areset_cycles", n, ARESET_CYC);
    repeat (10) @(negedge clk);
    pll_locked = 1'b1;
    repeat (SYNC_STAGES + 1 + 20) @(negedge clk);
    chk("glitch_pre_ready", sys_ready, 0);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    sb_push("glitch_fresh_window", SYNC_STAGES + STABLE_CYC + 1);
    wait_for(1, 8'd1, BUDGET, n);
    sb_pop(n);
    chk("glitch_retry", retry_cnt, 0);

    // Lock never arrives: three timed-out attempts, then FAIL
    drop_lock();
    for (int k = 1; k <= MAX_RETRY; k++) begin
      wait_for(0, 8'd0, BUDGET, n);
      chk("attempt_areset_cycles", n, ARESET_CYC);
      wait_for(0, 8'd1, BUDGET, n);
      chk("attempt_wait_cycles", n, LOCK_TIMEOUT);
      chk("attempt_retry_cnt", retry_cnt, k);
      chk("attempt_seq_fail", seq_fail, (k == MAX_RETRY) ? 1 : 0);
    end
    repeat (50) @(negedge clk);
    chk("fail_held", seq_fail, 1);
    chk("fail_areset", pll_areset, 1);
    chk("fail_retry", retry_cnt, MAX_RETRY);

    // restart leaves FAIL
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("restart_fail", seq_fail, 0);
    chk("restart_retry", retry_cnt, 0);
    chk("restart_areset", pll_areset, 1);
    wait_for(0, 8'd0, BUDGET, n);
    chk("restart_areset_cycles", n, ARESET_CYC);
    lock_and_run(20, "restart_ready_latency");

    // Short asynchronous reset pulse while in STABLE
    drop_lock();
    wait_for(0, 8'd0, BUDGET, n);
    repeat (3) @(negedge clk);
    pll_locked = 1'b1;
    repeat (30) @(negedge clk);
    chk("stable_pre_areset", pll_areset, 0);
    #1 sys_rst = 1'b1;
    #1;
    chk("async_rst_areset", pll_areset, 1);
    chk("async_rst_ready",  sys_ready,  0);
    chk("async_rst_fail",   seq_fail,   0);
    chk("async_rst_loss",   loss_cnt,   0);
    #1 sys_rst = 1'b0;
    exp_loss = 0;
    wait_for(0, 8'd0, BUDGET, n);
    chk("post_rst_areset_cycles", n, ARESET_CYC);
    sb_push("post_rst_ready_latency", STABLE_CYC + 1);
    wait_for(1, 8'd1, BUDGET, n);
    sb_pop(n);
    chk("post_rst_loss", loss_cnt, 0);

    // 300 losses saturate loss_cnt
    for (int i = 0; i < 300; i++) begin
      drop_lock();
      wait_for(0, 8'd0, BUDGET, n);
      lock_and_run(0, "loop_ready_latency");
    end
    chk("loss_saturated", loss_cnt, LOSS_EN ? 255 : 0);
    chk("scoreboard_drained", sb_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
